// File: rtl/inst_mem_responder_pkg.sv
// Shared types and helpers for the instruction-fetch responder slice.
package inst_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;

  typedef struct packed {
    logic        hit;
    logic        aligned;
    logic [31:0] index;
  } addr_decode_t;

  // Maps a byte address onto the store. span_bytes is 33 bits wide so that a
  // map ending exactly at the top of the 32-bit space does not wrap to zero.
  function automatic addr_decode_t decode_addr(input logic [31:0] addr,
                                               input logic [31:0] base,
                                               input logic [32:0] span_bytes);
    addr_decode_t d;
    logic [32:0]  limit;
    limit     = {1'b0, base} + span_bytes;
    d.aligned = (addr[1:0] == 2'b00);
    d.hit     = (addr >= base) && ({1'b0, addr} < limit);
    d.index   = (addr - base) >> 2;
    return d;
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// DEPTH x 32 instruction store: one synchronous write port for the loader and
// one registered read port for the fetch path.
module inst_mem_array #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_index,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH];

  // Loader write; the array contents are deliberately never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_index] <= wr_data;
    end
  end

  // Read register samples the array before a same-edge write lands (read-before-write).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_index];
    end
  end

endmodule

// File: rtl/inst_mem_responder.sv
// Responder end of the instruction-fetch interface: one outstanding request,
// response presented LATENCY idle cycles after acceptance.
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = DEFAULT_BASE,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  input  logic        ld_wen,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
  localparam logic [3:0]  LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  fetch_state_e state, next_state;
  logic [3:0]   wait_cnt;
  logic [31:0]  addr_q;
  logic [31:0]  rd_addr;
  logic         resp_err_q;
  logic         capture;
  logic         enter_resp;
  logic         mem_wen;
  logic [31:0]  mem_rd_data;
  addr_decode_t rd_dec;
  addr_decode_t ld_dec;
  logic         unused_idx_bits;

  assign rd_dec  = decode_addr(rd_addr, BASE, SPAN);
  assign ld_dec  = decode_addr(ld_addr, BASE, SPAN);
  assign mem_wen = ld_wen && ld_dec.hit && ld_dec.aligned;

  assign unused_idx_bits = ^{rd_dec.index[31:IDX_W], ld_dec.index[31:IDX_W]};

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_err_q ? '0 : mem_rd_data;

  // Next-state logic; with zero latency the read uses req_addr directly since it is not latched yet.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    enter_resp = 1'b0;
    rd_addr    = addr_q;
    case (state)
      IDLE: begin
        rd_addr = req_addr;
        if (req_valid) begin
          capture = 1'b1;
          if (LATENCY == 0) begin
            next_state = RESP;
            enter_resp = 1'b1;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          next_state = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register; reset drops any pending request immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Latched address, latency counter and fault flag captured on RESP entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q     <= '0;
      wait_cnt   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      if (capture) begin
        addr_q   <= req_addr;
        wait_cnt <= LAT_LOAD;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (enter_resp) begin
        resp_err_q <= !(rd_dec.hit && rd_dec.aligned);
      end
    end
  end

  inst_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (mem_wen),
    .wr_index (ld_dec.index[IDX_W-1:0]),
    .wr_data  (ld_data),
    .rd_en    (enter_resp),
    .rd_index (rd_dec.index[IDX_W-1:0]),
    .rd_data  (mem_rd_data)
  );

endmodule

// File: tb/tb_inst_mem_responder.sv
// Self-checking bench: a LATENCY=2 responder driven with directed and random
// fetches, plus a LATENCY=0 responder exercised back-to-back.
module tb_inst_mem_responder;

  localparam int          DEPTH_A = 1024;
  localparam int          LAT_A   = 2;
  localparam int          DEPTH_B = 16;
  localparam logic [31:0] BASE    = 32'h8000_0000;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic        req_valid_a, req_ready_a, resp_valid_a, resp_ready_a, resp_err_a, ld_wen_a;
  logic [31:0] req_addr_a, resp_data_a, ld_addr_a, ld_data_a;
  logic        req_valid_b, req_ready_b, resp_valid_b, resp_ready_b, resp_err_b, ld_wen_b;
  logic [31:0] req_addr_b, resp_data_b, ld_addr_b, ld_data_b;

  logic [31:0] model_a [DEPTH_A];
  logic [31:0] model_b [DEPTH_B];
  int          loaded_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  inst_mem_responder #(.DEPTH(DEPTH_A), .BASE(BASE), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_addr(req_addr_a),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
    .resp_data(resp_data_a), .resp_err(resp_err_a),
    .ld_wen(ld_wen_a), .ld_addr(ld_addr_a), .ld_data(ld_data_a)
  );

  inst_mem_responder #(.DEPTH(DEPTH_B), .BASE(BASE), .LATENCY(0)) dut_b (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
    .resp_data(resp_data_b), .resp_err(resp_err_b),
    .ld_wen(ld_wen_b), .ld_addr(ld_addr_b), .ld_data(ld_data_b)
  );

  // Counts one comparison and reports it when it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // True when addr is a word-aligned address inside a map of the given depth.
  function automatic bit in_map(input logic [31:0] addr, input int depth);
    longint a;
    a = longint'(addr);
    return (addr % 4 == 0) && (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * longint'(depth));
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr - BASE) / 4);
  endfunction

  // Reference response for an address, from the model contents.
  function automatic void expected_resp(input bit sel_b, input logic [31:0] addr,
                                        output logic [31:0] d, output logic e);
    if (in_map(addr, sel_b ? DEPTH_B : DEPTH_A)) begin
      e = 1'b0;
      d = sel_b ? model_b[word_of(addr)] : model_a[word_of(addr)];
    end else begin
      e = 1'b1;
      d = 32'd0;
    end
  endfunction

  // One loader write on the selected responder; bad addresses leave the model alone.
  task automatic loadWord(input bit sel_b, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    if (sel_b) begin
      ld_wen_b = 1'b1; ld_addr_b = addr; ld_data_b = data;
    end else begin
      ld_wen_a = 1'b1; ld_addr_a = addr; ld_data_a = data;
    end
    @(negedge clk);
    ld_wen_a = 1'b0;
    ld_wen_b = 1'b0;
    if (sel_b && in_map(addr, DEPTH_B)) model_b[word_of(addr)] = data;
    if (!sel_b && in_map(addr, DEPTH_A)) begin
      model_a[word_of(addr)] = data;
      loaded_q.push_back(word_of(addr));
    end
  endtask

  // One fetch on the LATENCY=2 responder: hold = extra backpressure cycles,
  // ld_cycle = cycle after acceptance in which the loader rewrites the same word (0 = none).
  task automatic applyStimulus(input logic [31:0] addr, input int hold,
                               input int ld_cycle, input logic [31:0] ld_val);
    logic [31:0] exp_d;
    logic        exp_e;
    int          waited;
    @(negedge clk);
    waited = 0;
    while (!req_ready_a && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_before_req", req_ready_a, 1);
    if (ld_cycle != 0 && ld_cycle < LAT_A && in_map(addr, DEPTH_A)) model_a[word_of(addr)] = ld_val;
    expected_resp(1'b0, addr, exp_d, exp_e);
    if (ld_cycle == LAT_A && in_map(addr, DEPTH_A)) model_a[word_of(addr)] = ld_val;
    req_valid_a  = 1'b1;
    req_addr_a   = addr;
    resp_ready_a = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= LAT_A + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid_a = 1'b0;
        req_addr_a  = $urandom;
      end
      ld_wen_a  = (k == ld_cycle);
      ld_addr_a = addr;
      ld_data_a = ld_val;
      if (k <= LAT_A) checkOutput("wait_valid_ready", {30'd0, resp_valid_a, req_ready_a}, 32'd0);
    end
    checkOutput("resp_valid_at_T+L+1", resp_valid_a, 1);
    checkOutput("resp_data", resp_data_a, exp_d);
    checkOutput("resp_err", resp_err_a, exp_e);
    checkOutput("ready_in_resp", req_ready_a, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("bp_valid", resp_valid_a, 1);
      checkOutput("bp_data", resp_data_a, exp_d);
      checkOutput("bp_err", resp_err_a, exp_e);
      checkOutput("bp_ready", req_ready_a, 0);
    end
    resp_ready_a = 1'b1;
    @(negedge clk);
    checkOutput("after_handshake", {30'd0, resp_valid_a, req_ready_a}, 32'd1);
    resp_ready_a = 1'b0;
  endtask

  // Hard stop in case something wedges the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    logic [31:0] addrs_b [$];
    logic [31:0] exp_d_q [$];
    logic        exp_e_q [$];
    logic [31:0] a, ed;
    logic        ee;
    int          issued, got, last_accept, cycle;
    bit          seen;

    req_valid_a = 0; req_addr_a = 0; resp_ready_a = 0; ld_wen_a = 0; ld_addr_a = 0; ld_data_a = 0;
    req_valid_b = 0; req_addr_b = 0; resp_ready_b = 0; ld_wen_b = 0; ld_addr_b = 0; ld_data_b = 0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready_a", req_ready_a, 1);
    checkOutput("rst_valid_a", resp_valid_a, 0);
    checkOutput("rst_data_a", resp_data_a, 0);
    checkOutput("rst_err_a", resp_err_a, 0);
    checkOutput("rst_ready_b", req_ready_b, 1);
    checkOutput("rst_valid_b", resp_valid_b, 0);
    rstn = 1'b1;

    loadWord(0, BASE, 32'h0010_0093);
    loadWord(0, BASE + 32'h4, 32'h1111_2222);
    loadWord(0, BASE + 32'h8, 32'h0BAD_0BAD);
    loadWord(0, BASE + 32'hFFC, 32'hCAFE_F00D);
    for (int i = 0; i < 20; i++) loadWord(0, BASE + 4 * $urandom_range(0, DEPTH_A - 1), $urandom);

    $display("[TB] basic fetch and backpressure");
    applyStimulus(BASE, 0, 0, 0);
    applyStimulus(BASE + 32'h4, 5, 0, 0);

    $display("[TB] faults");
    applyStimulus(32'h8000_0002, 0, 0, 0);
    applyStimulus(32'h7FFF_FFFC, 0, 0, 0);
    applyStimulus(32'h8000_1000, 0, 0, 0);
    applyStimulus(32'hFFFF_FFFC, 0, 0, 0);
    applyStimulus(32'h8000_0FFC, 0, 0, 0);

    $display("[TB] loader hazards");
    applyStimulus(BASE + 32'h8, 0, 1, 32'hDEAD_BEEF);
    applyStimulus(BASE + 32'h8, 0, 2, 32'h1234_5678);
    applyStimulus(BASE + 32'h8, 0, 0, 0);
    loadWord(0, 32'h8000_1000, 32'hBAD0_0001);
    loadWord(0, 32'h7FFF_FFFC, 32'hBAD0_0002);
    loadWord(0, 32'h8000_0006, 32'hBAD0_0003);
    applyStimulus(BASE, 0, 0, 0);
    applyStimulus(BASE + 32'h4, 0, 0, 0);
    applyStimulus(BASE + 32'hFFC, 0, 0, 0);

    $display("[TB] random fetches");
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom;
        if (in_map(a, DEPTH_A)) a[0] = 1'b1;
      end else begin
        a = BASE + 4 * loaded_q[$urandom_range(0, loaded_q.size() - 1)];
      end
      applyStimulus(a, $urandom_range(0, 3), $urandom_range(0, LAT_A), $urandom);
    end

    $display("[TB] reset during WAIT");
    @(negedge clk);
    req_valid_a = 1'b1;
    req_addr_a  = BASE;
    @(posedge clk);
    #2 rstn = 1'b0;
    req_valid_a = 1'b0;
    #1;
    checkOutput("async_rst_valid_ready", {30'd0, resp_valid_a, req_ready_a}, 32'd1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid_a) seen = 1'b1;
    end
    checkOutput("no_resp_after_reset", seen, 0);
    applyStimulus(BASE, 1, 0, 0);

    $display("[TB] zero-latency back-to-back");
    for (int i = 0; i < 8; i++) loadWord(1, BASE + 4 * i, $urandom);
    for (int i = 0; i < 6; i++) addrs_b.push_back(BASE + 4 * $urandom_range(0, 7));
    addrs_b.push_back(32'h8000_0040);
    addrs_b.push_back(32'h8000_0005);
    addrs_b.push_back(BASE + 32'h1C);
    issued = 0; got = 0; last_accept = -100; cycle = 0;
    @(negedge clk);
    req_valid_b  = 1'b1;
    resp_ready_b = 1'b1;
    while (got < addrs_b.size() && cycle < 200) begin
      if (resp_valid_b) begin
        checkOutput("b_resp_latency", 32'(cycle - last_accept), 1);
        checkOutput("b_resp_data", resp_data_b, exp_d_q.pop_front());
        checkOutput("b_resp_err", resp_err_b, exp_e_q.pop_front());
        got++;
      end
      if (req_ready_b && issued < addrs_b.size()) begin
        if (issued > 0) checkOutput("b_spacing", 32'(cycle - last_accept), 2);
        req_addr_b = addrs_b[issued];
        expected_resp(1'b1, addrs_b[issued], ed, ee);
        exp_d_q.push_back(ed);
        exp_e_q.push_back(ee);
        issued++;
        last_accept = cycle;
      end else if (issued == addrs_b.size()) begin
        req_valid_b = 1'b0;
      end
      @(negedge clk);
      cycle++;
    end
    checkOutput("b_all_responses", got, addrs_b.size());
    req_valid_b = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
